// File: rtl/frame_serializer.sv
// Unloads a W-bit frame as a stream of bytes, oldest (bits [7:0]) first.
// Ready/valid on both sides; all outputs come from registers.
module frame_serializer #(
  parameter int W  = 128,
  parameter int N  = W / 8,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] load_data,
  input  logic         load_valid,
  output logic         load_ready,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         byte_last,
  output logic         busy
);

  localparam logic       IDLE = 1'b0;
  localparam logic       SEND = 1'b1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  logic          state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shift_d = load_data;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      default: begin
        if (byte_ready) begin
          if (cnt_q == LAST_IDX) begin
            // Clear on exit so no stale frame data lingers in IDLE.
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
          end else begin
            shift_d = shift_q >> 8;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_out   = shift_q[7:0];
  assign byte_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign load_ready = (state_q == IDLE);
  // Gated by state: for N=1 the counter sits at the last index even in IDLE.
  assign byte_last  = (state_q == SEND) && (cnt_q == LAST_IDX);

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: default W=128 instance plus a W=8 instance.
module tb_frame_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] load_data;
  logic         load_valid;
  logic         load_ready;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready;
  logic         byte_last;
  logic         busy;

  logic [7:0]   ld8;
  logic         lv8;
  logic         lr8;
  logic [7:0]   bo8;
  logic         bv8;
  logic         br8;
  logic         bl8;
  logic         busy8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_serializer #(.W(128)) dut (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .byte_last(byte_last), .busy(busy)
  );

  frame_serializer #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .load_data(ld8), .load_valid(lv8),
    .load_ready(lr8), .byte_out(bo8), .byte_valid(bv8),
    .byte_ready(br8), .byte_last(bl8), .busy(busy8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] ramp(input logic [7:0] base);
    logic [127:0] f;
    f = '0;
    for (int k = 0; k < 16; k++) f[8*k +: 8] = base + 8'(k);
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b0; load_valid = 1'b0; load_data = '0; byte_ready = 1'b0;
    lv8 = 1'b0; ld8 = '0; br8 = 1'b0;
    #12;
    checks++;
    if ({byte_out, byte_valid, byte_last, busy, load_ready} !== {8'h00, 4'b0001}) begin
      errors++;
      $display("FAIL reset_during: out=%h v=%b l=%b busy=%b lr=%b, want 00 0 0 0 1",
               byte_out, byte_valid, byte_last, busy, load_ready);
    end
    step();
    rst = 1'b1;
    byte_ready = 1'b1;
    step(); step();
    checks++;
    if ({byte_out, byte_valid, byte_last, busy, load_ready} !== {8'h00, 4'b0001}) begin
      errors++;
      $display("FAIL reset_after_idle_ready: out=%h v=%b l=%b busy=%b lr=%b, want 00 0 0 0 1",
               byte_out, byte_valid, byte_last, busy, load_ready);
    end
  endtask

  task automatic test_basic_frame();
    load_data = ramp(8'h00); load_valid = 1'b1; byte_ready = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({byte_out, byte_valid, byte_last, load_ready, busy} !== {8'(i), 1'b1, (i == 15), 2'b01}) begin
        errors++;
        $display("FAIL basic_byte%0d: out=%h v=%b l=%b lr=%b busy=%b, want %h 1 %b 0 1",
                 i, byte_out, byte_valid, byte_last, load_ready, busy, 8'(i), (i == 15));
      end
      step();
    end
    checks++;
    if ({byte_valid, load_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL basic_after: v=%b lr=%b busy=%b, want 0 1 0", byte_valid, load_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    load_data = ramp(8'h00); load_valid = 1'b1; byte_ready = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({byte_out, byte_valid, byte_last} !== {8'(i), 1'b1, (i == 15)}) begin
        errors++;
        $display("FAIL bp_byte%0d: out=%h v=%b l=%b, want %h 1 %b",
                 i, byte_out, byte_valid, byte_last, 8'(i), (i == 15));
      end
      if (i == 5) begin
        byte_ready = 1'b0;
        repeat (3) begin
          step();
          checks++;
          if ({byte_out, byte_valid, byte_last} !== {8'h05, 2'b10}) begin
            errors++;
            $display("FAIL bp_hold: out=%h v=%b l=%b, want 05 1 0", byte_out, byte_valid, byte_last);
          end
        end
        byte_ready = 1'b1;
      end
      step();
    end
    checks++;
    if (byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_after: v=%b, want 0", byte_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lasts;
    lasts = 0;
    load_data = {16{8'hAA}}; load_valid = 1'b1; byte_ready = 1'b1;
    step();
    load_data = {16{8'h55}};
    for (int i = 0; i < 16; i++) begin
      if (byte_last === 1'b1) lasts++;
      checks++;
      if ({byte_out, byte_valid} !== {8'hAA, 1'b1}) begin
        errors++;
        $display("FAIL b2b_a%0d: out=%h v=%b, want aa 1", i, byte_out, byte_valid);
      end
      step();
    end
    checks++;
    if ({byte_valid, load_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_gap: v=%b lr=%b, want 0 1", byte_valid, load_ready);
    end
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (byte_last === 1'b1) lasts++;
      checks++;
      if ({byte_out, byte_valid} !== {8'h55, 1'b1}) begin
        errors++;
        $display("FAIL b2b_b%0d: out=%h v=%b, want 55 1", i, byte_out, byte_valid);
      end
      step();
    end
    checks++;
    if (lasts != 2 || byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_lasts: lasts=%0d v=%b, want 2 0", lasts, byte_valid);
    end
  endtask

  task automatic test_ignored_load();
    load_data = ramp(8'h00); load_valid = 1'b1; byte_ready = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        load_data = {16{8'hFF}};
        load_valid = 1'b1;
      end
      checks++;
      if ({byte_out, byte_valid, load_ready} !== {8'(i), 2'b10}) begin
        errors++;
        $display("FAIL ign_byte%0d: out=%h v=%b lr=%b, want %h 1 0",
                 i, byte_out, byte_valid, load_ready, 8'(i));
      end
      step();
    end
    checks++;
    if ({byte_valid, load_ready} !== 2'b01) begin
      errors++;
      $display("FAIL ign_gap: v=%b lr=%b, want 0 1", byte_valid, load_ready);
    end
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({byte_out, byte_valid, byte_last} !== {8'hFF, 1'b1, (i == 15)}) begin
        errors++;
        $display("FAIL ign_ff%0d: out=%h v=%b l=%b, want ff 1 %b", i, byte_out, byte_valid, byte_last, (i == 15));
      end
      step();
    end
  endtask

  task automatic test_reset_mid_frame();
    load_data = ramp(8'h00); load_valid = 1'b1; byte_ready = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (byte_out !== 8'h08) begin
      errors++;
      $display("FAIL rmf_pre: out=%h, want 08", byte_out);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({byte_out, byte_valid, byte_last, busy, load_ready} !== {8'h00, 4'b0001}) begin
      errors++;
      $display("FAIL rmf_async: out=%h v=%b l=%b busy=%b lr=%b, want 00 0 0 0 1",
               byte_out, byte_valid, byte_last, busy, load_ready);
    end
    step();
    rst = 1'b1;
    step();
    load_data = ramp(8'h10); load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({byte_out, byte_valid, byte_last} !== {8'h10 + 8'(i), 1'b1, (i == 15)}) begin
        errors++;
        $display("FAIL rmf_byte%0d: out=%h v=%b l=%b, want %h 1 %b",
                 i, byte_out, byte_valid, byte_last, 8'h10 + 8'(i), (i == 15));
      end
      step();
    end
  endtask

  task automatic test_w8();
    ld8 = 8'h5A; lv8 = 1'b1; br8 = 1'b1;
    checks++;
    if ({bl8, bv8, lr8} !== 3'b001) begin
      errors++;
      $display("FAIL w8_idle: l=%b v=%b lr=%b, want 0 0 1", bl8, bv8, lr8);
    end
    step();
    lv8 = 1'b0;
    checks++;
    if ({bo8, bv8, bl8, busy8, lr8} !== {8'h5A, 4'b1110}) begin
      errors++;
      $display("FAIL w8_send: out=%h v=%b l=%b busy=%b lr=%b, want 5a 1 1 1 0", bo8, bv8, bl8, busy8, lr8);
    end
    step();
    checks++;
    if ({bo8, bv8, bl8, busy8, lr8} !== {8'h00, 4'b0001}) begin
      errors++;
      $display("FAIL w8_after: out=%h v=%b l=%b busy=%b lr=%b, want 00 0 0 0 1", bo8, bv8, bl8, busy8, lr8);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    step();
    test_backpressure();
    step();
    test_back_to_back();
    step();
    test_ignored_load();
    step();
    test_reset_mid_frame();
    step();
    test_w8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
